// File: rtl/md5_core_scheduler_pkg.sv
// Shared definitions for the MD5 brute-force chunk scheduler:
// FSM state encodings, statistics counter width and a saturating increment.
package md5_core_scheduler_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int unsigned STATS_W = 16;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/md5_core_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter. Purely combinational: returns the
// one-hot grant and the next pointer value. The pointer register is owned
// by the caller so that a grant suppressed upstream leaves it untouched.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_rr,
    output logic [1:0] o_grant,
    output logic       o_rr_next
);

    // Pick the requester; the pointer always moves to the core not granted.
    always_comb begin
        o_grant   = '0;
        o_rr_next = i_rr;
        case (i_req)
            2'b11: begin
                o_grant   = i_rr ? 2'b10 : 2'b01;
                o_rr_next = ~i_rr;
            end
            2'b01: begin
                o_grant   = 2'b01;
                o_rr_next = 1'b1;
            end
            2'b10: begin
                o_grant   = 2'b10;
                o_rr_next = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md5_core_scheduler.sv
// MD5 brute-force core scheduler: deals key-space chunks to two cores in
// round-robin order, captures the first match, aborts both cores and hands
// the winning key to the result path. Optional per-core grant statistics
// are enabled with the macro MD5_SCHED_STATS_EN (ports chunks0/chunks1).
module md5_core_scheduler
    import md5_core_scheduler_pkg::*;
#(
    parameter int unsigned      KEY_W      = 48,
    parameter int unsigned      CHUNK_LOG2 = 16,
    parameter logic [KEY_W-1:0] KEY_MAX    = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             rewind,
    input  logic [1:0]       core_ready,
    output logic [1:0]       core_grant,
    output logic [KEY_W-1:0] core_base,
    input  logic [1:0]       core_found,
    input  logic [KEY_W-1:0] core_key0,
    input  logic [KEY_W-1:0] core_key1,
    output logic             core_abort,
    output logic             result_valid,
    output logic [KEY_W-1:0] result_key,
    input  logic             result_ready,
    output logic             busy,
    output logic             exhausted
`ifdef MD5_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0] chunks0,
    output logic [STATS_W-1:0] chunks1
`endif
);

    localparam logic [KEY_W:0] CHUNK_SZ = {{KEY_W{1'b0}}, 1'b1} << CHUNK_LOG2;

    logic [2:0]       r_state;
    logic [KEY_W-1:0] r_next_base;
    logic             r_rr;
    logic [1:0]       r_grant;
    logic [KEY_W-1:0] r_base;
    logic             r_abort;
    logic             r_res_valid;
    logic [KEY_W-1:0] r_res_key;
    logic             r_exhausted;

    logic             w_dispatch;
    logic [1:0]       w_req;
    logic [1:0]       w_arb_grant;
    logic             w_rr_next;
    logic             w_found_take;
    logic             w_do_grant;
    logic [KEY_W:0]   w_sum;
    logic [KEY_W:0]   w_end;
    logic             w_last;

    // The grant pulse is registered, so core_ready cannot yet reflect a
    // grant still on the bus; while one is pending no new grant is issued.
    // This gives the one-grant-every-other-cycle cadence with both ready.
    // Start in IDLE dispatches on the same edge to keep a 1-cycle latency.
    always_comb begin
        w_dispatch   = (r_state == ST_RUN) || ((r_state == ST_IDLE) && start);
        w_req        = (w_dispatch && (r_grant == 2'b00)) ? (core_ready & ~r_grant) : 2'b00;
        w_found_take = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && (core_found != 2'b00);
        w_do_grant   = (w_arb_grant != 2'b00) && !w_found_take;
        w_sum        = {1'b0, r_next_base} + CHUNK_SZ;
        w_end        = w_sum - 1'b1;
        w_last       = (w_end >= {1'b0, KEY_MAX});
    end

    rr_arbiter2 u_arb (
        .i_req     (w_req),
        .i_rr      (r_rr),
        .o_grant   (w_arb_grant),
        .o_rr_next (w_rr_next)
    );

    // Scheduler FSM, base counter and result capture; rewind behaves as reset.
    always_ff @(posedge clock) begin
        if (!reset || rewind) begin
            r_state     <= ST_IDLE;
            r_next_base <= '0;
            r_rr        <= 1'b0;
            r_grant     <= '0;
            r_base      <= '0;
            r_abort     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_key   <= '0;
            r_exhausted <= 1'b0;
        end else begin
            r_grant <= '0;
            if (w_found_take) begin
                r_res_key   <= core_found[0] ? core_key0 : core_key1;
                r_res_valid <= 1'b1;
                r_abort     <= 1'b1;
                r_state     <= ST_REPORT;
            end else begin
                if ((r_state == ST_IDLE) && start) begin
                    r_state <= ST_RUN;
                end
                if (w_do_grant) begin
                    r_grant     <= w_arb_grant;
                    r_base      <= r_next_base;
                    r_next_base <= w_sum[KEY_W-1:0];
                    r_rr        <= w_rr_next;
                    if (w_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                if ((r_state == ST_DRAIN) && (core_ready == 2'b11) && (r_grant == 2'b00)) begin
                    r_state     <= ST_DONE;
                    r_exhausted <= 1'b1;
                end
                if ((r_state == ST_REPORT) && result_ready) begin
                    r_state     <= ST_DONE;
                    r_res_valid <= 1'b0;
                end
            end
        end
    end

`ifdef MD5_SCHED_STATS_EN
    logic [STATS_W-1:0] r_chunks0;
    logic [STATS_W-1:0] r_chunks1;

    // Per-core saturating count of chunks handed out.
    always_ff @(posedge clock) begin
        if (!reset || rewind) begin
            r_chunks0 <= '0;
            r_chunks1 <= '0;
        end else if (w_do_grant) begin
            if (w_arb_grant[0]) r_chunks0 <= sat_inc(r_chunks0);
            if (w_arb_grant[1]) r_chunks1 <= sat_inc(r_chunks1);
        end
    end

    assign chunks0 = r_chunks0;
    assign chunks1 = r_chunks1;
`endif

    assign core_grant   = r_grant;
    assign core_base    = r_base;
    assign core_abort   = r_abort;
    assign result_valid = r_res_valid;
    assign result_key   = r_res_key;
    assign exhausted    = r_exhausted;
    assign busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN) || (r_state == ST_REPORT);

endmodule

// File: tb/tb_md5_core_scheduler.sv
// Self-checking bench for md5_core_scheduler with KEY_W=8, CHUNK_LOG2=4,
// KEY_MAX=8'h3F (four chunks). Table-driven dispatch sequence, hand-written
// corner sequences, then random stimulus against a chunk-index reference model.
module tb_md5_core_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rewind = 1'b0;
    logic [1:0] core_ready = '0;
    logic [1:0] core_found = '0;
    logic [7:0] core_key0 = '0;
    logic [7:0] core_key1 = '0;
    logic       result_ready = 1'b0;
    logic [1:0] core_grant;
    logic [7:0] core_base;
    logic       core_abort;
    logic       result_valid;
    logic [7:0] result_key;
    logic       busy;
    logic       exhausted;

    int n_checks = 0;
    int n_errors = 0;

    md5_core_scheduler #(
        .KEY_W      (8),
        .CHUNK_LOG2 (4),
        .KEY_MAX    (8'h3F)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rewind       (rewind),
        .core_ready   (core_ready),
        .core_grant   (core_grant),
        .core_base    (core_base),
        .core_found   (core_found),
        .core_key0    (core_key0),
        .core_key1    (core_key1),
        .core_abort   (core_abort),
        .result_valid (result_valid),
        .result_key   (result_key),
        .result_ready (result_ready),
        .busy         (busy),
        .exhausted    (exhausted)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef enum {M_OFF, M_SEARCH, M_FLUSH, M_SHOW, M_END} mphase_t;
    mphase_t    m_ph = M_OFF;
    int         m_idx = 0;      // index of next chunk to hand out
    int         m_rr = 0;       // core preferred when both are free
    logic [1:0] m_grant = '0;
    logic [7:0] m_base = '0;
    logic       m_abort = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_key = '0;
    logic       m_exh = 1'b0;

    task automatic model_dispatch(input logic [1:0] prev_grant);
        int pick;
        pick = -1;
        if (prev_grant == 2'b00) begin
            if (core_ready == 2'b11) pick = m_rr;
            else if (core_ready == 2'b01) pick = 0;
            else if (core_ready == 2'b10) pick = 1;
        end
        if (pick >= 0) begin
            m_grant = (pick == 0) ? 2'b01 : 2'b10;
            m_base  = 8'(m_idx * 16);
            m_rr    = 1 - pick;
            if ((m_idx + 1) * 16 - 1 >= 63) m_ph = M_FLUSH;
            m_idx++;
        end
    endtask

    task automatic model_edge();
        logic [1:0] prev_grant;
        if (!reset || rewind) begin
            m_ph = M_OFF; m_idx = 0; m_rr = 0; m_grant = '0; m_base = '0;
            m_abort = 0; m_valid = 0; m_key = '0; m_exh = 0;
            return;
        end
        prev_grant = m_grant;
        m_grant = '0;
        if ((m_ph == M_SEARCH || m_ph == M_FLUSH) && core_found != 2'b00) begin
            m_key   = core_found[0] ? core_key0 : core_key1;
            m_valid = 1;
            m_abort = 1;
            m_ph    = M_SHOW;
        end else begin
            case (m_ph)
                M_OFF: if (start) begin
                    m_ph = M_SEARCH;
                    model_dispatch(prev_grant);
                end
                M_SEARCH: model_dispatch(prev_grant);
                M_FLUSH: if (core_ready == 2'b11 && prev_grant == 2'b00) begin
                    m_ph  = M_END;
                    m_exh = 1;
                end
                M_SHOW: if (result_ready) begin
                    m_ph    = M_END;
                    m_valid = 0;
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [21:0] dut_vec();
        return {core_grant, core_base, core_abort, result_valid, result_key, busy, exhausted};
    endfunction

    function automatic logic [21:0] model_vec();
        logic mbusy;
        mbusy = (m_ph == M_SEARCH) || (m_ph == M_FLUSH) || (m_ph == M_SHOW);
        return {m_grant, m_base, m_abort, m_valid, m_key, mbusy, m_exh};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic rw, input logic [1:0] rdy,
                         input logic [1:0] fnd, input logic [7:0] k0, input logic [7:0] k1,
                         input logic rr);
        start = st; rewind = rw; core_ready = rdy; core_found = fnd;
        core_key0 = k0; core_key1 = k1; result_ready = rr;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 2'b00, 2'b00, 8'h00, 8'h00, 0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // ---------------- table for dispatch sequence ----------------
    typedef struct {
        logic       st;
        logic [1:0] rdy;
        logic [1:0] gnt;
        logic [7:0] base;
        logic       bsy;
        logic       exh;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{st: 1'b1, rdy: 2'b11, gnt: 2'b01, base: 8'h00, bsy: 1'b1, exh: 1'b0};
        tbl[1] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b00, base: 8'h00, bsy: 1'b1, exh: 1'b0};
        tbl[2] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b10, base: 8'h10, bsy: 1'b1, exh: 1'b0};
        tbl[3] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b00, base: 8'h10, bsy: 1'b1, exh: 1'b0};
        tbl[4] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b01, base: 8'h20, bsy: 1'b1, exh: 1'b0};
        tbl[5] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b00, base: 8'h20, bsy: 1'b1, exh: 1'b0};
        tbl[6] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b10, base: 8'h30, bsy: 1'b1, exh: 1'b0};
        tbl[7] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b00, base: 8'h30, bsy: 1'b1, exh: 1'b0};
        tbl[8] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b00, base: 8'h30, bsy: 1'b0, exh: 1'b1};
        tbl[9] = '{st: 1'b0, rdy: 2'b11, gnt: 2'b00, base: 8'h30, bsy: 1'b0, exh: 1'b1};

        // Reset state: every output zero.
        do_reset();
        chk("reset_outputs", 32'(dut_vec()), 32'h0);

        // Four chunks, both cores ready, then drain and exhaustion.
        for (int unsigned i = 0; i < 10; i++) begin
            drive(tbl[i].st, 0, tbl[i].rdy, 2'b00, 8'h00, 8'h00, 0);
            step();
            chk("t1_grant", 32'(core_grant), 32'(tbl[i].gnt));
            chk("t1_base", 32'(core_base), 32'(tbl[i].base));
            chk("t1_busy", 32'(busy), 32'(tbl[i].bsy));
            chk("t1_exh_valid", 32'({exhausted, result_valid}), 32'({tbl[i].exh, 1'b0}));
        end

        // Only core1 ready, then only core0.
        do_reset();
        drive(1, 0, 2'b10, 2'b00, 8'h00, 8'h00, 0);
        step();
        chk("t2_first_grant", 32'({core_grant, core_base}), 32'({2'b10, 8'h00}));
        drive(0, 0, 2'b01, 2'b00, 8'h00, 8'h00, 0);
        step();
        chk("t2_gap", 32'(core_grant), 32'h0);
        step();
        chk("t2_second_grant", 32'({core_grant, core_base}), 32'({2'b01, 8'h10}));

        // Both found in RUN: core 0 key wins.
        drive(0, 0, 2'b00, 2'b11, 8'h17, 8'h2A, 0);
        step();
        chk("t3_result", 32'({result_valid, result_key, core_abort, core_grant}),
            32'({1'b1, 8'h17, 1'b1, 2'b00}));
        drive(0, 0, 2'b00, 2'b10, 8'h00, 8'h99, 0);
        step();
        chk("t3_found_ignored", 32'({result_valid, result_key}), 32'({1'b1, 8'h17}));

        // Rewind in REPORT, then restart from base 0.
        drive(0, 1, 2'b00, 2'b00, 8'h00, 8'h00, 0);
        step();
        chk("t5_rewind_zero", 32'(dut_vec()), 32'h0);
        drive(1, 0, 2'b11, 2'b00, 8'h00, 8'h00, 0);
        step();
        chk("t5_restart", 32'({core_grant, core_base}), 32'({2'b01, 8'h00}));

        // Found while both cores eligible: grant suppressed, base held.
        drive(0, 0, 2'b11, 2'b00, 8'h00, 8'h00, 0);
        step();
        step();
        chk("t4_second", 32'({core_grant, core_base}), 32'({2'b10, 8'h10}));
        step();
        chk("t4_gap", 32'(core_grant), 32'h0);
        drive(0, 0, 2'b11, 2'b01, 8'h55, 8'h66, 0);
        step();
        chk("t4_no_grant", 32'({core_grant, core_base}), 32'({2'b00, 8'h10}));
        chk("t4_result", 32'({result_valid, result_key, core_abort}), 32'({1'b1, 8'h55, 1'b1}));
        drive(0, 0, 2'b11, 2'b00, 8'h00, 8'h00, 0);
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            chk("t4_hold", 32'({result_valid, result_key, busy}), 32'({1'b1, 8'h55, 1'b1}));
        end
        drive(0, 0, 2'b11, 2'b00, 8'h00, 8'h00, 1);
        step();
        chk("t4_done", 32'({result_valid, result_key, core_abort, busy, exhausted}),
            32'({1'b0, 8'h55, 1'b1, 1'b0, 1'b0}));
        drive(1, 0, 2'b11, 2'b01, 8'h77, 8'h00, 0);
        step();
        chk("t4_done_hold", 32'({core_grant, result_valid, result_key, core_abort, busy}),
            32'({2'b00, 1'b0, 8'h55, 1'b1, 1'b0}));

        // Reset mid-RUN.
        drive(0, 1, 2'b00, 2'b00, 8'h00, 8'h00, 0);
        step();
        drive(1, 0, 2'b11, 2'b00, 8'h00, 8'h00, 0);
        step();
        drive(0, 0, 2'b11, 2'b00, 8'h00, 8'h00, 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("t6_reset_zero", 32'(dut_vec()), 32'h0);
        reset = 1'b1;

        // Random stimulus against the reference model.
        for (int unsigned ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int unsigned c = 0; c < 400; c++) begin
                drive(($urandom % 8) == 0,
                      ($urandom % 97) == 0,
                      2'($urandom),
                      (($urandom % 25) == 0) ? 2'($urandom) : 2'b00,
                      8'($urandom), 8'($urandom),
                      ($urandom % 4) == 0);
                step();
                chk("rand_outputs", 32'(dut_vec()), 32'(model_vec()));
                chk("rand_exh_vs_valid", 32'(exhausted & result_valid), 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
